// File: rtl/rf_spi_slave.sv
// rf_spi_slave: oversampled mode-0 SPI responder turning short/long frames into single register reads or writes
module rf_spi_slave #(
  parameter int WAIT_BITS = 4,
  parameter int SYNC_FF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_oe,
  output logic [9:0] reg_addr,
  output logic       reg_long,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_data,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rd_data,
  output logic       busy,
  output logic       frame_err
);
  typedef enum logic [2:0] {IDLE, HDR, TURN, DATA, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_FF:0] sck_q, cs_q;
  logic [SYNC_FF-1:0] sdi_q;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic [9:0] sh_q, sh_d, addr_q, addr_d;
  logic [10:0] sh_in;
  logic [7:0] rd_sh_q, rd_sh_d, wr_data_q, wr_data_d;
  logic long_q, long_d, rd_q, rd_d, sdo_q, sdo_d;
  logic rd_en_q, rd_en_d, rd_pend_q, wr_en_q, wr_en_d, err_q, err_d;
  logic sdi_s, sck_rise, sck_fall, cs_rise, cs_fall, hdr_long, hdr_last, turn_last;
  assign sdi_s = sdi_q[SYNC_FF-1];
  assign sck_rise = sck_q[SYNC_FF-1] & ~sck_q[SYNC_FF];
  assign sck_fall = ~sck_q[SYNC_FF-1] & sck_q[SYNC_FF];
  assign cs_rise = cs_q[SYNC_FF-1] & ~cs_q[SYNC_FF];
  assign cs_fall = ~cs_q[SYNC_FF-1] & cs_q[SYNC_FF];
  assign sh_in = {sh_q, sdi_s};
  assign cnt_inc = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1;
  assign hdr_long = cnt_q == 4'd11;
  assign hdr_last = hdr_long | (cnt_q == 4'd7 & ~sh_q[6]);
  assign turn_last = cnt_q == 4'(WAIT_BITS - 1);
  assign busy = state_q != IDLE;
  assign sdo_oe = busy;
  assign sdo = sdo_q;
  assign reg_addr = addr_q;
  assign reg_long = long_q;
  assign reg_wr_en = wr_en_q;
  assign reg_wr_data = wr_data_q;
  assign reg_rd_en = rd_en_q;
  assign frame_err = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    rd_sh_d = rd_pend_q ? reg_rd_data : rd_sh_q;
    wr_data_d = wr_data_q;
    addr_d = addr_q;
    long_d = long_q;
    rd_d = rd_q;
    sdo_d = 1'b0;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    err_d = 1'b0;
    if (state_q != IDLE && cs_rise) begin
      state_d = IDLE;
      err_d = state_q != DONE;
    end else begin
      case (state_q)
        IDLE: if (cs_fall) begin
          state_d = HDR;
          cnt_d = '0;
          sh_d = '0;
        end
        HDR: if (sck_rise) begin
          sh_d = sh_in[9:0];
          cnt_d = hdr_last ? 4'd0 : cnt_inc;
          if (hdr_last) begin
            addr_d = hdr_long ? sh_in[10:1] : {4'b0, sh_in[6:1]};
            long_d = hdr_long;
            rd_d = ~sdi_s;
            state_d = hdr_long ? TURN : DATA;
            rd_en_d = ~hdr_long & ~sdi_s;
          end
        end
        TURN: if (sck_rise) begin
          cnt_d = turn_last ? 4'd0 : cnt_inc;
          state_d = turn_last ? DATA : TURN;
          rd_en_d = turn_last & rd_q;
        end
        DATA: begin
          sdo_d = rd_q & (sck_fall ? rd_sh_q[7] : sdo_q);
          rd_sh_d = sck_fall ? {rd_sh_q[6:0], 1'b0} : rd_sh_d;
          if (sck_rise) begin
            sh_d = sh_in[9:0];
            cnt_d = cnt_inc;
            if (cnt_q == 4'd7) begin
              state_d = DONE;
              sdo_d = 1'b0;
              wr_en_d = ~rd_q;
              wr_data_d = rd_q ? wr_data_q : sh_in[7:0];
            end
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sck_q <= '0;
      cs_q <= '0;
      sdi_q <= '0;
      cnt_q <= '0;
      sh_q <= '0;
      rd_sh_q <= '0;
      wr_data_q <= '0;
      addr_q <= '0;
      long_q <= 1'b0;
      rd_q <= 1'b0;
      sdo_q <= 1'b0;
      rd_en_q <= 1'b0;
      rd_pend_q <= 1'b0;
      wr_en_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sck_q <= {sck_q[SYNC_FF-1:0], sck};
      cs_q <= {cs_q[SYNC_FF-1:0], cs};
      sdi_q <= {sdi_q[SYNC_FF-2:0], sdi};
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      rd_sh_q <= rd_sh_d;
      wr_data_q <= wr_data_d;
      addr_q <= addr_d;
      long_q <= long_d;
      rd_q <= rd_d;
      sdo_q <= sdo_d;
      rd_en_q <= rd_en_d;
      rd_pend_q <= rd_en_q;
      wr_en_q <= wr_en_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_rf_spi_slave.sv
// tb_rf_spi_slave: randomized SPI master with a frame-level register model and strobe scoreboard
module tb_rf_spi_slave;
  localparam int HP = 5;
  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, cs = 1'b1, sdi = 1'b0;
  logic sdo, sdo_oe, reg_long, reg_wr_en, reg_rd_en, busy, frame_err;
  logic [9:0] reg_addr, rd_addr;
  logic [7:0] reg_wr_data, reg_rd_data = 8'h00;
  always #5 clk = ~clk;
  rf_spi_slave dut (
    .clk(clk), .rst(rst), .sck(sck), .cs(cs), .sdi(sdi), .sdo(sdo), .sdo_oe(sdo_oe),
    .reg_addr(reg_addr), .reg_long(reg_long), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .busy(busy), .frame_err(frame_err)
  );
  typedef struct packed {logic wr; logic [9:0] addr; logic lng; logic [7:0] data;} txn_t;
  txn_t exp_q[$];
  txn_t e;
  logic [7:0] bank_mem [1024];
  logic [7:0] model_mem [1024];
  int total = 0, passes = 0, fails = 0, err_seen = 0, err_exp = 0, cs_hi = 0;
  bit rd_pend = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else passes++;
  endtask
  always @(negedge clk) begin
    reg_rd_data = rd_pend ? bank_mem[rd_addr] : 8'($urandom);
    rd_pend = 1'b0;
    cs_hi = cs ? cs_hi + 1 : 0;
    if (!rst) begin
      chk("strobe_excl", {31'b0, reg_wr_en & reg_rd_en}, 0);
      if (cs_hi >= 5) chk("idle_outs", {29'b0, sdo, sdo_oe, busy}, 0);
      if (frame_err) err_seen++;
      if (reg_wr_en | reg_rd_en) begin
        if (exp_q.size() == 0) chk("unexpected_strobe", {22'b0, reg_addr}, 32'hffff_ffff);
        else begin
          e = exp_q.pop_front();
          chk("strobe_kind", {31'b0, reg_wr_en}, {31'b0, e.wr});
          chk("strobe_addr", {22'b0, reg_addr}, {22'b0, e.addr});
          chk("strobe_long", {31'b0, reg_long}, {31'b0, e.lng});
          if (e.wr) chk("wr_data", {24'b0, reg_wr_data}, {24'b0, e.data});
        end
        if (reg_wr_en) bank_mem[reg_addr] = reg_wr_data;
        if (reg_rd_en) begin
          rd_pend = 1'b1;
          rd_addr = reg_addr;
        end
      end
    end
  end
  task automatic xfer(input logic [23:0] bits, input int nb, input int stop_at, input int extra,
                      input bit do_rst, output logic [23:0] got);
    got = '0;
    cs = 1'b0;
    repeat (HP) @(negedge clk);
    chk("busy_on", {30'b0, busy, sdo_oe}, 3);
    for (int i = 0; i < nb + extra && i != stop_at; i++) begin
      sdi = i < nb ? bits[23-i] : 1'($urandom);
      repeat (HP) @(negedge clk);
      if (i < nb) got[23-i] = sdo;
      else chk("extra_sdo", {31'b0, sdo}, 0);
      sck = 1'b1;
      repeat (HP) @(negedge clk);
      sck = 1'b0;
    end
    if (do_rst) begin
      rst = 1'b1;
      @(negedge clk);
      chk("rst_outs", {7'b0, sdo, sdo_oe, reg_addr, reg_long, reg_wr_en, reg_wr_data, reg_rd_en, busy,
                       frame_err}, 0);
      rst = 1'b0;
    end
    repeat (HP) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("busy_off", {30'b0, busy, sdo_oe}, 0);
  endtask
  task automatic frame(input bit lng, input bit wr, input logic [9:0] a, input logic [7:0] d,
                       input int stop_at, input int extra, input bit do_rst, output logic [23:0] got);
    logic [23:0] bits, exp_sdo;
    int nb;
    bit full;
    nb = lng ? 24 : 16;
    if (!lng) a = {4'b0, a[5:0]};
    full = stop_at >= nb && !do_rst;
    bits = lng ? {1'b1, a, wr, 4'($urandom), d} : {1'b0, a[5:0], wr, d, 8'h00};
    exp_sdo = '0;
    if (!wr && lng) exp_sdo[7:0] = model_mem[a];
    if (!wr && !lng) exp_sdo[15:8] = model_mem[a];
    if (full) begin
      exp_q.push_back('{wr: wr, addr: a, lng: lng, data: d});
      if (wr) model_mem[a] = d;
    end else if (!do_rst) err_exp++;
    xfer(bits, nb, stop_at, extra, do_rst, got);
    if (full) chk("sdo_bits", {8'b0, got}, {8'b0, exp_sdo});
    chk("strobes_done", exp_q.size(), 0);
    chk("err_count", err_seen, err_exp);
  endtask
  initial begin
    logic [23:0] got;
    logic [9:0] a;
    bit lng, wr;
    int stop;
    for (int i = 0; i < 1024; i++) begin
      bank_mem[i] = 8'($urandom);
      model_mem[i] = bank_mem[i];
    end
    repeat (3) @(negedge clk);
    chk("reset_outs", {7'b0, sdo, sdo_oe, reg_addr, reg_long, reg_wr_en, reg_wr_data, reg_rd_en, busy,
                       frame_err}, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    frame(1'b0, 1'b1, 10'h015, 8'hA5, 99, 0, 1'b0, got);
    chk("t1_addr", {22'b0, reg_addr}, 32'h015);
    chk("t1_data", {24'b0, reg_wr_data}, 32'hA5);
    chk("t1_long", {31'b0, reg_long}, 0);
    bank_mem[10'h200] = 8'h3C;
    model_mem[10'h200] = 8'h3C;
    frame(1'b1, 1'b0, 10'h200, 8'($urandom), 99, 0, 1'b0, got);
    chk("t2_sdo", {24'b0, got[7:0]}, 32'b00111100);
    chk("t2_addr", {22'b0, reg_addr}, 32'h200);
    chk("t2_long", {31'b0, reg_long}, 1);
    bank_mem[10'h03F] = 8'h81;
    model_mem[10'h03F] = 8'h81;
    frame(1'b0, 1'b0, 10'h03F, 8'($urandom), 99, 0, 1'b0, got);
    chk("t3_sdo", {24'b0, got[15:8]}, 32'b10000001);
    frame(1'b1, 1'b1, 10'h155, 8'h99, 10, 0, 1'b0, got);
    chk("t4_errs", err_seen, 1);
    frame(1'b0, 1'b1, 10'h001, 8'h55, 99, 0, 1'b0, got);
    chk("t4_data", {24'b0, reg_wr_data}, 32'h55);
    chk("t4_addr", {22'b0, reg_addr}, 32'h001);
    frame(1'b1, 1'b1, 10'h123, 8'h77, 10, 0, 1'b1, got);
    frame(1'b0, 1'b1, 10'h02A, 8'h3C, 99, 0, 1'b0, got);
    chk("t5_data", {24'b0, reg_wr_data}, 32'h3C);
    frame(1'b0, 1'b1, 10'h007, 8'h96, 99, 5, 1'b0, got);
    frame(1'b0, 1'b0, 10'h007, 8'h00, 99, 0, 1'b0, got);
    chk("t6_readback", {24'b0, got[15:8]}, 32'h96);
    for (int n = 0; n < 40; n++) begin
      lng = 1'($urandom);
      wr = 1'($urandom);
      a = {2'($urandom), 4'b0, 4'($urandom)};
      stop = 99;
      if (wr && $urandom_range(0, 5) == 0) stop = $urandom_range(0, lng ? 23 : 15);
      frame(lng, wr, a, 8'($urandom), stop, $urandom_range(0, 1) * $urandom_range(1, 3), 1'b0, got);
    end
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
